// File: rtl/mem_stage_wb.sv
// MIPS memory stage with the MEM/WB pipeline register: byte-lane data memory,
// load extension, write-back select, all captured into one register every cycle.
module mem_stage_wb #(
  parameter int ADDR_BITS = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  inRegDest,
  input  logic [31:0] inALUResult,
  input  logic [31:0] inData2,
  input  logic [31:0] inData1,
  input  logic [31:0] inPCCounter,
  input  logic        inHazardRegWrite,
  input  logic [1:0]  inHazardMemRead,
  input  logic [1:0]  inHazardMemWrite,
  input  logic [2:0]  inHazardMemToRegMux,
  output logic [4:0]  outRegDest,
  output logic        outRegWrite,
  output logic [31:0] outWriteData,
  output logic [31:0] outALUResult,
  output logic [31:0] outMemData,
  output logic        outMisaligned
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Little-endian: lane 0 holds the byte at the lowest address of the word.
  logic [3:0][7:0] r_mem [DEPTH] = '{default: '0};

  logic [ADDR_BITS-1:0] w_idx;
  logic [1:0]           w_lane;
  logic                 w_ld_mis;
  logic                 w_st_mis;
  logic                 w_misaligned;
  logic [31:0]          w_rd_word;
  logic [15:0]          w_half;
  logic [7:0]           w_byte;
  logic [31:0]          w_load_data;
  logic [3:0]           w_byte_en;
  logic [31:0]          w_wr_word;
  logic [31:0]          w_link;
  logic [31:0]          w_wb_data;

  logic [4:0]  r_reg_dest;
  logic        r_reg_write;
  logic [31:0] r_write_data;
  logic [31:0] r_alu_result;
  logic [31:0] r_mem_data;
  logic        r_misaligned;

  assign w_idx  = inALUResult[ADDR_BITS+1:2];
  assign w_lane = inALUResult[1:0];

  always_comb begin
    w_ld_mis = 1'b0;
    w_st_mis = 1'b0;
    case (inHazardMemRead)
      2'b01:   w_ld_mis = (w_lane != 2'b00);
      2'b10:   w_ld_mis = w_lane[0];
      default: w_ld_mis = 1'b0;
    endcase
    case (inHazardMemWrite)
      2'b01:   w_st_mis = (w_lane != 2'b00);
      2'b10:   w_st_mis = w_lane[0];
      default: w_st_mis = 1'b0;
    endcase
  end

  // Any fault in the combined access kills both the store and the load data.
  assign w_misaligned = w_ld_mis | w_st_mis;

  assign w_rd_word = r_mem[w_idx];
  assign w_half    = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
  assign w_byte    = w_rd_word[{w_lane, 3'b000} +: 8];

  always_comb begin
    w_load_data = 32'd0;
    if (!w_misaligned) begin
      case (inHazardMemRead)
        2'b01:   w_load_data = w_rd_word;
        2'b10:   w_load_data = {{16{w_half[15]}}, w_half};
        2'b11:   w_load_data = {{24{w_byte[7]}}, w_byte};
        default: w_load_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_byte_en = 4'b0000;
    w_wr_word = 32'd0;
    case (inHazardMemWrite)
      2'b01: begin
        w_byte_en = 4'b1111;
        w_wr_word = inData2;
      end
      2'b10: begin
        w_byte_en = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wr_word = {2{inData2[15:0]}};
      end
      2'b11: begin
        w_byte_en = 4'b0001 << w_lane;
        w_wr_word = {4{inData2[7:0]}};
      end
      default: begin
        w_byte_en = 4'b0000;
        w_wr_word = 32'd0;
      end
    endcase
    if (w_misaligned) w_byte_en = 4'b0000;
  end

  // Read above is asynchronous, so a same-cycle load sees the pre-store word.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) r_mem[w_idx][i] <= w_wr_word[8*i +: 8];
      end
    end
  end

  assign w_link = inPCCounter + 32'd8;

  always_comb begin
    w_wb_data = inALUResult;
    case (inHazardMemToRegMux)
      3'b001:  w_wb_data = w_load_data;
      3'b010:  w_wb_data = w_link;
      3'b011:  w_wb_data = inData1;
      3'b100:  w_wb_data = inData2;
      default: w_wb_data = inALUResult;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_reg_dest   <= 5'd0;
      r_reg_write  <= 1'b0;
      r_write_data <= 32'd0;
      r_alu_result <= 32'd0;
      r_mem_data   <= 32'd0;
      r_misaligned <= 1'b0;
    end else begin
      r_reg_dest   <= inRegDest;
      r_reg_write  <= inHazardRegWrite;
      r_write_data <= w_wb_data;
      r_alu_result <= inALUResult;
      r_mem_data   <= w_load_data;
      r_misaligned <= w_misaligned;
    end
  end

  assign outRegDest    = r_reg_dest;
  assign outRegWrite   = r_reg_write;
  assign outWriteData  = r_write_data;
  assign outALUResult  = r_alu_result;
  assign outMemData    = r_mem_data;
  assign outMisaligned = r_misaligned;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Scoreboard bench for mem_stage_wb: a byte-array reference model predicts each
// transaction's registered outputs; a monitor compares them one cycle later.
module tb_mem_stage_wb;

  localparam int ADDR_BITS = 10;
  localparam int NBYTES    = 4 << ADDR_BITS;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  inRegDest;
  logic [31:0] inALUResult, inData2, inData1, inPCCounter;
  logic        inHazardRegWrite;
  logic [1:0]  inHazardMemRead, inHazardMemWrite;
  logic [2:0]  inHazardMemToRegMux;
  logic [4:0]  outRegDest;
  logic        outRegWrite;
  logic [31:0] outWriteData, outALUResult, outMemData;
  logic        outMisaligned;

  mem_stage_wb #(.ADDR_BITS(ADDR_BITS)) dut (
    .Clk(Clk), .Rst(Rst),
    .inRegDest(inRegDest), .inALUResult(inALUResult), .inData2(inData2),
    .inData1(inData1), .inPCCounter(inPCCounter),
    .inHazardRegWrite(inHazardRegWrite), .inHazardMemRead(inHazardMemRead),
    .inHazardMemWrite(inHazardMemWrite), .inHazardMemToRegMux(inHazardMemToRegMux),
    .outRegDest(outRegDest), .outRegWrite(outRegWrite), .outWriteData(outWriteData),
    .outALUResult(outALUResult), .outMemData(outMemData), .outMisaligned(outMisaligned)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wd;
    logic [31:0] alu;
    logic [31:0] md;
    logic        mis;
    logic        has_c;
    logic [31:0] c;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mem_model [NBYTES];
  int          checks = 0;
  int          errors = 0;
  int          txn_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Behavioural model: memory as a flat byte array, accesses as byte ranges.
  task automatic issue(input logic rst, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] pc,
                       input logic rw, input logic [1:0] mr, input logic [1:0] mw,
                       input logic [2:0] mtr, input logic has_c, input logic [31:0] c);
    exp_t e;
    int a, ld_sz, st_sz;
    logic [31:0] v;
    logic mis;
    @(negedge Clk);
    Rst = rst; inRegDest = rd; inALUResult = alu; inData2 = d2; inData1 = d1;
    inPCCounter = pc; inHazardRegWrite = rw; inHazardMemRead = mr;
    inHazardMemWrite = mw; inHazardMemToRegMux = mtr;
    e = '{id: txn_id, rd: 5'd0, rw: 1'b0, wd: 32'd0, alu: 32'd0, md: 32'd0,
          mis: 1'b0, has_c: has_c, c: c};
    txn_id++;
    if (!rst) begin
      a     = int'(alu % NBYTES);
      ld_sz = (mr == 2'b01) ? 4 : (mr == 2'b10) ? 2 : (mr == 2'b11) ? 1 : 0;
      st_sz = (mw == 2'b01) ? 4 : (mw == 2'b10) ? 2 : (mw == 2'b11) ? 1 : 0;
      mis   = (ld_sz > 1 && (a % ld_sz) != 0) || (st_sz > 1 && (a % st_sz) != 0);
      v = 32'd0;
      if (ld_sz > 0 && !mis) begin
        for (int k = 0; k < ld_sz; k++) v = v | (32'(mem_model[a + k]) << (8 * k));
        if (ld_sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        if (ld_sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
      end
      if (st_sz > 0 && !mis)
        for (int k = 0; k < st_sz; k++) mem_model[a + k] = 8'(d2 >> (8 * k));
      e.rd  = rd;
      e.rw  = rw;
      e.alu = alu;
      e.md  = v;
      e.mis = mis;
      case (mtr)
        3'd1:    e.wd = v;
        3'd2:    e.wd = pc + 32'd8;
        3'd3:    e.wd = d1;
        3'd4:    e.wd = d2;
        default: e.wd = alu;
      endcase
    end
    sb_q.push_back(e);
  endtask

  task automatic op(input logic [31:0] alu, input logic [31:0] d2, input logic [1:0] mr,
                    input logic [1:0] mw, input logic [2:0] mtr, input logic has_c,
                    input logic [31:0] c);
    issue(1'b0, 5'd8, alu, d2, 32'h11, 32'h0040_0000, mr != 2'b00, mr, mw, mtr, has_c, c);
  endtask

  // Monitor: the register captures every cycle, so one entry retires per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("outRegDest",    e.id, 32'(outRegDest),    32'(e.rd));
        chk("outRegWrite",   e.id, 32'(outRegWrite),   32'(e.rw));
        chk("outWriteData",  e.id, outWriteData,       e.wd);
        chk("outALUResult",  e.id, outALUResult,       e.alu);
        chk("outMemData",    e.id, outMemData,         e.md);
        chk("outMisaligned", e.id, 32'(outMisaligned), 32'(e.mis));
        if (e.has_c) chk("directed_wb", e.id, outWriteData, e.c);
        $display("txn %0d rd=%0d rw=%b wd=%h md=%h mis=%b", e.id, outRegDest,
                 outRegWrite, outWriteData, outMemData, outMisaligned);
      end
    end
  end

  initial begin
    int waited;
    for (int i = 0; i < NBYTES; i++) mem_model[i] = 8'h00;
    Rst = 1'b1; inRegDest = '0; inALUResult = '0; inData2 = '0; inData1 = '0;
    inPCCounter = '0; inHazardRegWrite = 1'b0; inHazardMemRead = '0;
    inHazardMemWrite = '0; inHazardMemToRegMux = '0;

    // Reset with random inputs, including a store that must be dropped.
    issue(1'b1, 5'($urandom), 32'h30, 32'hCAFEF00D, $urandom, $urandom, 1'b1,
          2'b00, 2'b01, 3'($urandom), 1'b0, 32'd0);
    issue(1'b1, 5'($urandom), $urandom, $urandom, $urandom, $urandom, 1'b1,
          2'($urandom), 2'($urandom), 3'($urandom), 1'b0, 32'd0);
    op(32'h30, 32'd0, 2'b01, 2'b00, 3'd1, 1'b1, 32'h0000_0000);

    // Word round trip, then lane writes and sign extension.
    op(32'h10, 32'hDEAD_BEEF, 2'b00, 2'b01, 3'd0, 1'b0, 32'd0);
    op(32'h10, 32'd0, 2'b01, 2'b00, 3'd1, 1'b1, 32'hDEAD_BEEF);
    op(32'h12, 32'h0000_007F, 2'b00, 2'b11, 3'd0, 1'b0, 32'd0);
    op(32'h10, 32'd0, 2'b01, 2'b00, 3'd1, 1'b1, 32'hDE7F_BEEF);
    op(32'h13, 32'd0, 2'b11, 2'b00, 3'd1, 1'b1, 32'hFFFF_FFDE);
    op(32'h10, 32'd0, 2'b10, 2'b00, 3'd1, 1'b1, 32'hFFFF_BEEF);
    op(32'h12, 32'h0000_1234, 2'b00, 2'b10, 3'd0, 1'b0, 32'd0);
    op(32'h10, 32'd0, 2'b01, 2'b00, 3'd1, 1'b1, 32'h1234_BEEF);

    // Misalignment and address wrap.
    op(32'h11, 32'h5555_5555, 2'b00, 2'b01, 3'd0, 1'b0, 32'd0);
    op(32'h10, 32'd0, 2'b01, 2'b00, 3'd1, 1'b1, 32'h1234_BEEF);
    op(32'h13, 32'd0, 2'b10, 2'b00, 3'd1, 1'b1, 32'h0000_0000);
    op(32'h1010, 32'hA5A5_A5A5, 2'b00, 2'b01, 3'd0, 1'b0, 32'd0);
    op(32'h10, 32'd0, 2'b01, 2'b00, 3'd1, 1'b1, 32'hA5A5_A5A5);

    // Write-back select.
    issue(1'b0, 5'd3, 32'h40, 32'h22, 32'h11, 32'h0040_0000, 1'b1, 2'b00, 2'b00, 3'd0, 1'b1, 32'h40);
    issue(1'b0, 5'd3, 32'h40, 32'h22, 32'h11, 32'h0040_0000, 1'b1, 2'b00, 2'b00, 3'd2, 1'b1, 32'h0040_0008);
    issue(1'b0, 5'd3, 32'h40, 32'h22, 32'h11, 32'h0040_0000, 1'b1, 2'b00, 2'b00, 3'd3, 1'b1, 32'h11);
    issue(1'b0, 5'd3, 32'h40, 32'h22, 32'h11, 32'h0040_0000, 1'b1, 2'b00, 2'b00, 3'd4, 1'b1, 32'h22);
    issue(1'b0, 5'd3, 32'h40, 32'h22, 32'h11, 32'h0040_0000, 1'b1, 2'b00, 2'b00, 3'd7, 1'b1, 32'h40);
    issue(1'b0, 5'd3, 32'h40, 32'h22, 32'h11, 32'hFFFF_FFFC, 1'b1, 2'b00, 2'b00, 3'd2, 1'b1, 32'h0000_0004);

    // Back-to-back sb/lb, then a simultaneous lw+sw returning the old word.
    for (int i = 0; i < 4; i++) begin
      op(32'h20 + i, 32'h80 + i, 2'b00, 2'b11, 3'd0, 1'b0, 32'd0);
      op(32'h20 + i, 32'd0, 2'b11, 2'b00, 3'd1, 1'b1, 32'hFFFF_FF80 + i);
    end
    op(32'h20, 32'h0BAD_CAFE, 2'b01, 2'b01, 3'd1, 1'b1, 32'h8382_8180);
    op(32'h20, 32'd0, 2'b01, 2'b00, 3'd1, 1'b1, 32'h0BAD_CAFE);

    // Random traffic over a small window, with high address bits to exercise wrap.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] addr;
      addr = {$urandom_range(0, 7) << 12} | 32'($urandom_range(0, 63));
      issue(($urandom_range(0, 49) == 0), 5'($urandom), addr, $urandom, $urandom,
            $urandom, 1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
            1'b0, 32'd0);
    end

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge Clk);
      waited++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
